// File: rtl/bist_signature_analyzer.sv
// -----------------------------------------------------------------------------
// bist_signature_analyzer
//
// BIST response analyzer. It compacts a DUT response stream into a
// multiple-input signature register (MISR) over a fixed window of PATTERNS
// captures. At the end of the window it compares the signature with GOLDEN and
// reports pass/fail. A start/busy/done handshake sequences repeated runs.
//
// Handshake: start is sampled only in IDLE or DONE. The edge that samples it
// clears the MISR and the capture counter and raises busy. resp is captured on
// each of the following PATTERNS edges. The edge that takes the last capture
// drops busy and raises done, with pass valid. done stays high, and pass keeps
// its value, until start begins another run. Holding start high in DONE starts
// the next run on the following edge, so busy rises in the same cycle that
// done falls. start during RUN and resp outside RUN are ignored.
//
// Optional feature (macro BIST_ABORT_EN): adds an abort input. abort high at an
// edge in RUN returns the block to IDLE. The signature keeps its current value
// and done/pass are 0. abort wins over the last-capture transition. abort has
// no effect in IDLE or DONE.
//
// Parameters:
//   W        response width (W <= SIG_W)
//   SIG_W    MISR width (>= 2)
//   TAPS     feedback tap mask; bit i set XORs sig[i] into the feedback
//   PATTERNS responses compacted per run (>= 1)
//   GOLDEN   expected final signature
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous reset, active-low
//   start      run request
//   resp       DUT response word
//   abort      (BIST_ABORT_EN only) cancel the current run
//   busy       high while in RUN
//   done       high in DONE
//   pass       final signature == GOLDEN, valid while done is high
//   signature  current MISR contents
//   state      FSM state for debug (0 IDLE, 1 RUN, 2 DONE)
//
// All outputs come straight from flops. No input reaches an output
// combinationally.
// -----------------------------------------------------------------------------
module bist_signature_analyzer #(
    parameter int              W        = 3,
    parameter int              SIG_W    = 8,
    parameter logic [SIG_W-1:0] TAPS    = 8'hB8,
    parameter int              PATTERNS = 15,
    parameter logic [SIG_W-1:0] GOLDEN  = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [W-1:0]     resp,
`ifdef BIST_ABORT_EN
    input  logic             abort,
`endif
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [SIG_W-1:0] signature,
    output logic [1:0]       state
);

    localparam int CNT_W = $clog2(PATTERNS + 1);
    // Counter value present while the final response word is captured.
    localparam logic [CNT_W-1:0] LAST = CNT_W'(PATTERNS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           st, st_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic [SIG_W-1:0] sig_d;
    logic [SIG_W-1:0] misr_next;
    logic [SIG_W-1:0] resp_ext;
    logic             fb;
    logic             busy_d, done_d, pass_d;
    logic             abort_hit;
    logic             last_cap;

`ifdef BIST_ABORT_EN
    assign abort_hit = abort;
`else
    assign abort_hit = 1'b0;
`endif

    assign last_cap = (cnt == LAST);

    // MISR step. The shift moves sig[i-1] into bit i. The tap feedback enters
    // bit 0. The response word is folded into the low W bits, and the upper
    // bits only shift.
    assign fb        = ^(signature & TAPS);
    assign resp_ext  = SIG_W'(resp);
    assign misr_next = {signature[SIG_W-2:0], fb} ^ resp_ext;

    // -------------------------------------------------------------------------
    // State register, together with the registered outputs and datapath.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st        <= S_IDLE;
            cnt       <= '0;
            signature <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
        end else begin
            st        <= st_d;
            cnt       <= cnt_d;
            signature <= sig_d;
            busy      <= busy_d;
            done      <= done_d;
            pass      <= pass_d;
        end
    end

    assign state = st;

    // -------------------------------------------------------------------------
    // Next-state logic.
    // -------------------------------------------------------------------------
    always_comb begin
        st_d = st;
        case (st)
            S_IDLE: begin
                if (start) st_d = S_RUN;
            end
            S_RUN: begin
                if (abort_hit)     st_d = S_IDLE;
                else if (last_cap) st_d = S_DONE;
            end
            S_DONE: begin
                if (start) st_d = S_RUN;
            end
            default: st_d = S_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Output and datapath next values. These are registered by the state
    // register process, so busy, done and pass line up with the state they
    // describe.
    // -------------------------------------------------------------------------
    always_comb begin
        sig_d  = signature;
        cnt_d  = cnt;
        pass_d = pass;
        busy_d = (st_d == S_RUN);
        done_d = (st_d == S_DONE);
        case (st)
            S_IDLE, S_DONE: begin
                if (start) begin
                    // New run: seed the MISR and restart the window.
                    sig_d  = '0;
                    cnt_d  = '0;
                    pass_d = 1'b0;
                end
            end
            S_RUN: begin
                if (abort_hit) begin
                    // Signature is frozen. No verdict is produced.
                    pass_d = 1'b0;
                end else begin
                    sig_d = misr_next;
                    cnt_d = cnt + CNT_W'(1);
                    // The verdict uses the value being loaded on this edge,
                    // so pass is valid in the first DONE cycle.
                    if (last_cap) pass_d = (misr_next == GOLDEN);
                end
            end
            default: begin
                sig_d  = '0;
                cnt_d  = '0;
                pass_d = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_bist_signature_analyzer.sv
// -----------------------------------------------------------------------------
// tb_bist_signature_analyzer
//
// Bench for bist_signature_analyzer. It drives several instances that share
// clk and rst:
//   u4  : PATTERNS=4,  GOLDEN=0     all-zero response, expect pass
//   u2a : PATTERNS=2,  GOLDEN=8'h02 known sequence, expect pass
//   u2b : PATTERNS=2,  GOLDEN=8'h03 same sequence, expect fail
//   u3  : PATTERNS=3,  GOLDEN=0     start held high, back-to-back runs
//   u15 : defaults                   random runs, reset mid-run, abort
// Expected {pass, signature} pairs are computed by a reference MISR model.
// They are queued when the stimulus is driven and popped when done rises.
// -----------------------------------------------------------------------------
module tb_bist_signature_analyzer;

    logic clk;
    logic rst;
    logic abort_off;

    logic       start4, start2, start3, start15, abort15;
    logic [2:0] resp4, resp2, resp3, resp15;

    logic       busy4, done4, pass4;
    logic [7:0] sig4;
    logic [1:0] st4;
    logic       busy2a, done2a, pass2a;
    logic [7:0] sig2a;
    logic [1:0] st2a;
    logic       busy2b, done2b, pass2b;
    logic [7:0] sig2b;
    logic [1:0] st2b;
    logic       busy3, done3, pass3;
    logic [7:0] sig3;
    logic [1:0] st3;
    logic       busy15, done15, pass15;
    logic [7:0] sig15;
    logic [1:0] st15;

    int tests_run = 0;
    int fail_cnt  = 0;

    logic [8:0] exp_q[$];   // {pass, signature}
    logic [8:0] exp_v;
    logic [7:0] m;
    logic [2:0] r;

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- DUT instances ----------------
    bist_signature_analyzer #(.PATTERNS(4), .GOLDEN(8'h00)) u4 (
        .clk(clk), .rst(rst), .start(start4), .resp(resp4),
`ifdef BIST_ABORT_EN
        .abort(abort_off),
`endif
        .busy(busy4), .done(done4), .pass(pass4), .signature(sig4), .state(st4));

    bist_signature_analyzer #(.PATTERNS(2), .GOLDEN(8'h02)) u2a (
        .clk(clk), .rst(rst), .start(start2), .resp(resp2),
`ifdef BIST_ABORT_EN
        .abort(abort_off),
`endif
        .busy(busy2a), .done(done2a), .pass(pass2a), .signature(sig2a), .state(st2a));

    bist_signature_analyzer #(.PATTERNS(2), .GOLDEN(8'h03)) u2b (
        .clk(clk), .rst(rst), .start(start2), .resp(resp2),
`ifdef BIST_ABORT_EN
        .abort(abort_off),
`endif
        .busy(busy2b), .done(done2b), .pass(pass2b), .signature(sig2b), .state(st2b));

    bist_signature_analyzer #(.PATTERNS(3), .GOLDEN(8'h00)) u3 (
        .clk(clk), .rst(rst), .start(start3), .resp(resp3),
`ifdef BIST_ABORT_EN
        .abort(abort_off),
`endif
        .busy(busy3), .done(done3), .pass(pass3), .signature(sig3), .state(st3));

    bist_signature_analyzer u15 (
        .clk(clk), .rst(rst), .start(start15), .resp(resp15),
`ifdef BIST_ABORT_EN
        .abort(abort15),
`endif
        .busy(busy15), .done(done15), .pass(pass15), .signature(sig15), .state(st15));

    // ---------------- watchdog ----------------
    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, observed=running required=finished");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    function automatic logic [7:0] misr_model(input logic [7:0] s, input logic [2:0] rw);
        return {s[6:0], ^(s & 8'hB8)} ^ {5'b0, rw};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp)
        else begin
            fail_cnt++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Rising edge, then settle 1 time unit: inputs are driven and outputs
    // sampled away from the active edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Full random run on u15. When mid_start is set, start is pulsed during
    // the run, and that pulse must be ignored.
    task automatic run15(input bit mid_start);
        start15 = 1'b1;
        step();
        start15 = 1'b0;
        check("u15 busy after start", busy15, 1);
        check("u15 sig seeded", sig15, 0);
        m = 8'h00;
        for (int k = 0; k < 15; k++) begin
            r = 3'($urandom_range(0, 7));
            resp15 = r;
            m = misr_model(m, r);
            start15 = (mid_start && k == 7);
            if (k == 14) exp_q.push_back({(m == 8'h00), m});
            step();
            if (k < 14) begin
                check("u15 busy in run", busy15, 1);
                check("u15 sig in run", sig15, m);
            end else begin
                exp_v = exp_q.pop_front();
                check("u15 done", done15, 1);
                check("u15 busy at done", busy15, 0);
                check("u15 sig at done", sig15, exp_v[7:0]);
                check("u15 pass at done", pass15, exp_v[8]);
            end
        end
        start15 = 1'b0;
        step();
        check("u15 done held", done15, 1);
        check("u15 sig held", sig15, exp_v[7:0]);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst = 1'b0;
        abort_off = 1'b0;
        start4 = 0; start2 = 0; start3 = 0; start15 = 0; abort15 = 0;
        resp4 = 0; resp2 = 0; resp3 = 0; resp15 = 0;

        // Reset state.
        #12;
        check("rst busy", busy15, 0);
        check("rst done", done15, 0);
        check("rst pass", pass15, 0);
        check("rst sig", sig15, 0);
        check("rst state", st15, 0);
        check("rst u4 done", done4, 0);
        rst = 1'b1;

        // resp in IDLE is ignored.
        for (int i = 0; i < 3; i++) begin
            resp15 = 3'($urandom_range(1, 7));
            step();
            check("idle sig", sig15, 0);
            check("idle busy", busy15, 0);
        end

        // PATTERNS=4, all-zero response: 4 busy cycles, then pass.
        start4 = 1'b1;
        exp_q.push_back({1'b1, 8'h00});
        step();
        start4 = 1'b0;
        check("u4 busy c0", busy4, 1);
        check("u4 sig seed", sig4, 0);
        for (int i = 1; i < 4; i++) begin
            step();
            check("u4 busy", busy4, 1);
            check("u4 not done", done4, 0);
        end
        step();
        exp_v = exp_q.pop_front();
        check("u4 busy end", busy4, 0);
        check("u4 done", done4, 1);
        check("u4 pass", pass4, exp_v[8]);
        check("u4 sig", sig4, exp_v[7:0]);

        // PATTERNS=2, responses 001 then 000: signature 01, then 02.
        start2 = 1'b1;
        exp_q.push_back({1'b1, 8'h02});
        step();
        start2 = 1'b0;
        resp2 = 3'b001;
        step();
        check("u2a sig cap1", sig2a, 8'h01);
        check("u2a busy cap1", busy2a, 1);
        resp2 = 3'b000;
        step();
        exp_v = exp_q.pop_front();
        check("u2a done", done2a, 1);
        check("u2a sig", sig2a, exp_v[7:0]);
        check("u2a pass", pass2a, exp_v[8]);
        check("u2b done", done2b, 1);
        check("u2b sig", sig2b, 8'h02);
        check("u2b pass", pass2b, 0);

        // Back-to-back runs on u3 with start held high.
        start3 = 1'b1;
        for (int run = 0; run < 3; run++) begin
            step();
            check("u3 busy restart", busy3, 1);
            check("u3 done low", done3, 0);
            check("u3 sig reseed", sig3, 0);
            m = 8'h00;
            for (int k = 0; k < 3; k++) begin
                r = 3'($urandom_range(0, 7));
                resp3 = r;
                m = misr_model(m, r);
                if (k == 2) exp_q.push_back({(m == 8'h00), m});
                step();
                if (k < 2) begin
                    check("u3 busy", busy3, 1);
                end else begin
                    exp_v = exp_q.pop_front();
                    check("u3 done", done3, 1);
                    check("u3 busy at done", busy3, 0);
                    check("u3 sig", sig3, exp_v[7:0]);
                    check("u3 pass", pass3, exp_v[8]);
                end
            end
        end
        start3 = 1'b0;
        resp3 = 3'b111;
        step();
        check("u3 hold done", done3, 1);
        check("u3 hold sig", sig3, exp_v[7:0]);

        // Random runs on u15. The second run pulses start mid-run.
        run15(1'b0);
        run15(1'b1);

        // Reset mid-run, after 5 captures.
        start15 = 1'b1;
        step();
        start15 = 1'b0;
        for (int k = 0; k < 5; k++) begin
            resp15 = 3'($urandom_range(1, 7));
            step();
        end
        check("pre-reset busy", busy15, 1);
        #2;
        rst = 1'b0;
        #1;
        check("mid rst busy", busy15, 0);
        check("mid rst done", done15, 0);
        check("mid rst pass", pass15, 0);
        check("mid rst sig", sig15, 0);
        check("mid rst state", st15, 0);
        #1;
        rst = 1'b1;
        step();
        check("post rst idle", st15, 0);
        run15(1'b0);

`ifdef BIST_ABORT_EN
        // Abort at capture 2: the block returns to IDLE with the signature
        // frozen.
        start15 = 1'b1;
        step();
        start15 = 1'b0;
        r = 3'($urandom_range(1, 7));
        resp15 = r;
        m = misr_model(8'h00, r);
        step();
        check("abort cap1 sig", sig15, m);
        abort15 = 1'b1;
        resp15 = 3'($urandom_range(0, 7));
        step();
        abort15 = 1'b0;
        check("abort busy", busy15, 0);
        check("abort done", done15, 0);
        check("abort pass", pass15, 0);
        check("abort state", st15, 0);
        check("abort sig frozen", sig15, m);
        run15(1'b0);
        // abort in DONE has no effect.
        abort15 = 1'b1;
        step();
        abort15 = 1'b0;
        check("abort in done", done15, 1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
        $finish;
    end

endmodule
